sram_arbiter: RTL and testbench

Sequential arbiter and access sequencer for the single external 16-bit SRAM, shared by the CPU instruction-fetch port (I) and the data load/store port (D). It replaces clock-phase multiplexing with explicit req/ack handshakes and a multi-cycle SRAM timing FSM. It drives the board SRAM pins directly and sits between the pipeline's IF/MEM stages and the chip.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_grant.sv | 42 ++++
 rtl/sram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter.
// Optional round-robin grant is enabled by defining SRAM_ARBITER_RR_EN.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_SAMPLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEFAULT_RD_WAIT = 1;

endpackage

// File: rtl/sram_arb_grant.sv
// rtl/sram_arb_grant.sv - I/D grant selector; SRAM_ARBITER_RR_EN selects
// round-robin on contention, otherwise D has fixed priority.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic take_i,
  output logic port_o
);

`ifdef SRAM_ARBITER_RR_EN
  logic last_q, last_d;

  always_comb begin
    port_o = PORT_D;
    if (i_req_i && d_req_i) begin
      port_o = (last_q == PORT_D) ? PORT_I : PORT_D;
    end else if (i_req_i) begin
      port_o = PORT_I;
    end
    last_d = take_i ? port_o : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_q <= PORT_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_fixed;

  // With fixed priority no history is kept, so clock/reset/take are not needed.
  assign unused_fixed = ^{clk_i, rstn_i, take_i};
  assign port_o       = d_req_i ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - arbiter and timing sequencer for the shared 16-bit SRAM.
// Grant policy follows SRAM_ARBITER_RR_EN (see sram_arb_grant).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = DEFAULT_RD_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iData,
  input  logic              dReq,
  input  logic              dWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdata,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic [17:0]       addrBus,
  output logic              memRead,
  output logic              memWrite,
  output logic              memEnable
);

  localparam int WAIT_LOAD = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;

  sram_state_t       state_q, state_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic [1:0]        wait_q, wait_d;
  logic              iack_q, iack_d;
  logic              dack_q, dack_d;
  logic              grant_port;
  logic              take;
  logic              drive_en;

  assign take = (state_q == ST_IDLE) && (iReq || dReq);

  sram_arb_grant u_grant (
    .clk_i   (clk),
    .rstn_i  (rst),
    .i_req_i (iReq),
    .d_req_i (dReq),
    .take_i  (take),
    .port_o  (grant_port)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      port_q   <= PORT_I;
      addr_q   <= '0;
      wdata_q  <= '0;
      idata_q  <= '0;
      drdata_q <= '0;
      wait_q   <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
      wait_q   <= wait_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idata_d  = idata_q;
    drdata_d = drdata_q;
    wait_d   = wait_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          port_d  = grant_port;
          addr_d  = (grant_port == PORT_D) ? dAddr : iAddr;
          wdata_d = dWdata;
          wait_d  = 2'(WAIT_LOAD);
          if (grant_port == PORT_D && dWrite) begin
            state_d = ST_WR_SETUP;
          end else if (RD_WAIT == 0) begin
            state_d = ST_RD_SAMPLE;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        wait_d = wait_q - 2'd1;
        if (wait_q == 2'd0) begin
          state_d = ST_RD_SAMPLE;
        end
      end
      // Ack is registered so it lands in the IDLE cycle that can re-grant.
      ST_RD_SAMPLE: begin
        state_d = ST_IDLE;
        if (port_q == PORT_D) begin
          dack_d   = 1'b1;
          drdata_d = dataBus;
        end else begin
          iack_d  = 1'b1;
          idata_d = dataBus;
        end
      end
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: begin
        state_d = ST_WR_HOLD;
        dack_d  = 1'b1;
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    memEnable = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b1;
    drive_en  = 1'b0;
    case (state_q)
      ST_RD_WAIT, ST_RD_SAMPLE: begin
        memEnable = 1'b0;
        memRead   = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        memEnable = 1'b0;
        drive_en  = 1'b1;
      end
      ST_WR_PULSE: begin
        memEnable = 1'b0;
        memWrite  = 1'b0;
        drive_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign dataBus = drive_en ? wdata_q : {DATA_W{1'bz}};
  assign addrBus = {{(18 - ADDR_W){1'b0}}, addr_q};
  assign iAck    = iack_q;
  assign dAck    = dack_q;
  assign iData   = idata_q;
  assign dRdata  = drdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with an SRAM pin model
// and a transaction-level reference memory; honours SRAM_ARBITER_RR_EN.
module tb_sram_arbiter;

  localparam int          RDW  = 1;
  localparam logic [15:0] KEEP = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iReq = 1'b0, dReq = 1'b0, dWrite = 1'b0;
  logic [15:0] iAddr = '0, dAddr = '0, dWdata = '0;
  logic        iAck, dAck;
  logic [15:0] iData, dRdata;
  wire  [15:0] dataBus;
  logic [17:0] addrBus;
  logic        memRead, memWrite, memEnable;

  int errors = 0;
  int checks = 0;

  logic [15:0] sram [0:65535];
  logic        mem_ready = 1'b0;
  logic        prev_we_low = 1'b0;
  logic [15:0] ref_mem [logic [15:0]];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_WAIT(RDW)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iData(iData),
    .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWdata(dWdata),
    .dAck(dAck), .dRdata(dRdata),
    .dataBus(dataBus), .addrBus(addrBus),
    .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable)
  );

  // SRAM drives on OE+CE; an idle keeper makes any stray DUT drive visible as contention.
  assign dataBus = (!memEnable && !memRead) ? sram[addrBus[15:0]] : 16'hzzzz;
  assign dataBus = memEnable ? KEEP : 16'hzzzz;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SRAM commits on WE rising while CE is still low.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 65536; a++) sram[a] <= init_word(16'(a));
      mem_ready <= 1'b1;
    end else if (prev_we_low && memWrite && !memEnable) begin
      sram[addrBus[15:0]] <= dataBus;
    end
    prev_we_low <= !memWrite;
  end

  always @(negedge clk) begin
    if (rst && mem_ready) begin
      check("oe_we_excl", 32'(!memRead && !memWrite), 32'd0);
      if (memEnable) check("bus_idle", 32'(dataBus), 32'(KEEP));
      if (!memRead && !memEnable) check("bus_read", 32'(dataBus), 32'(sram[addrBus[15:0]]));
      check("addr_hi", 32'(addrBus[17:16]), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic port, input logic [15:0] addr, input string tag);
    int cyc = 0, oe = 0;
    logic ack;
    logic [17:0] first_addr = '0;
    if (port) begin dReq = 1'b1; dWrite = 1'b0; dAddr = addr; end
    else begin iReq = 1'b1; iAddr = addr; end
    do begin
      step();
      cyc++;
      if (cyc == 1) first_addr = addrBus;
      if (!memRead) oe++;
      ack = port ? dAck : iAck;
    end while (!ack && cyc < 20);
    iReq = 1'b0;
    dReq = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(2 + RDW));
    check({tag, "_data"}, 32'(port ? dRdata : iData), 32'(ref_word(addr)));
    check({tag, "_oe"}, 32'(oe), 32'(RDW + 1));
    check({tag, "_addr"}, 32'(first_addr), {14'd0, addr});
    step();
    check({tag, "_pulse"}, 32'({iAck, dAck}), 32'd0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input string tag);
    int cyc = 0, we = 0;
    dReq = 1'b1; dWrite = 1'b1; dAddr = addr; dWdata = data;
    do begin
      step();
      cyc++;
      if (!memWrite) we++;
    end while (!dAck && cyc < 20);
    dReq = 1'b0;
    ref_mem[addr] = data;
    check({tag, "_lat"}, 32'(cyc), 32'd3);
    check({tag, "_we"}, 32'(we), 32'd1);
    step();
    check({tag, "_pulse"}, 32'(dAck), 32'd0);
  endtask

  initial begin
    logic [15:0] a, w;
    logic        p;
    logic        seq [4];
    int          n, cyc;

    repeat (3) step();
    check("rst_acks", 32'({iAck, dAck}), 32'd0);
    check("rst_idata", 32'(iData), 32'd0);
    check("rst_drdata", 32'(dRdata), 32'd0);
    check("rst_strobes", 32'({memRead, memWrite, memEnable}), 32'd7);
    check("rst_addr", 32'(addrBus), 32'd0);
    check("rst_bus", 32'(dataBus), 32'(KEEP));
    rst = 1'b1;
    step();

    do_read(1'b0, 16'h0010, "i_beef");
    check("i_beef_val", 32'(iData), 32'h0000BEEF);

    do_write(16'h0200, 16'h1234, "d_wr");
    do_read(1'b1, 16'h0200, "d_rd");
    check("d_rd_val", 32'(dRdata), 32'h00001234);
    check("sram_0200", 32'(sram[16'h0200]), 32'h00001234);

    // Back-to-back fetches: new address presented in the ack cycle.
    iReq = 1'b1; iAddr = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      do begin step(); cyc++; end while (!iAck && cyc < 20);
      check($sformatf("b2b%0d_gap", k), 32'(cyc), 32'(2 + RDW));
      check($sformatf("b2b%0d_data", k), 32'(iData), 32'(ref_word(16'(k))));
      if (k == 3) iReq = 1'b0;
      else iAddr = 16'(k + 1);
    end
    step();

    do_read(1'b0, 16'hFFFF, "i_ffff");

    // Contention: last grant was I, so round-robin starts with D.
    dReq = 1'b1; dWrite = 1'b0; dAddr = 16'h0444;
    iReq = 1'b1; iAddr = 16'h0555;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      step();
      cyc++;
      if (dAck) begin
        seq[n] = 1'b1; n++;
        check("cont_d_data", 32'(dRdata), 32'(ref_word(16'h0444)));
      end else if (iAck) begin
        seq[n] = 1'b0; n++;
        check("cont_i_data", 32'(iData), 32'(ref_word(16'h0555)));
      end
    end
    iReq = 1'b0; dReq = 1'b0;
    check("cont_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) begin
`ifdef SRAM_ARBITER_RR_EN
      check($sformatf("cont_grant%0d", k), 32'(seq[k]), 32'((k % 2) == 0));
`else
      check($sformatf("cont_grant%0d", k), 32'(seq[k]), 32'd1);
`endif
    end
    step();

    // Reset during the WE pulse drops the write.
    dReq = 1'b1; dWrite = 1'b1; dAddr = 16'h0300; dWdata = 16'h5A3C;
    cyc = 0;
    do begin step(); cyc++; end while (memWrite && cyc < 20);
    check("rst_mid_reach", 32'(memWrite), 32'd0);
    rst = 1'b0;
    step();
    check("rst_mid_strobes", 32'({memRead, memWrite, memEnable}), 32'd7);
    check("rst_mid_ack", 32'(dAck), 32'd0);
    check("rst_mid_bus", 32'(dataBus), 32'(KEEP));
    dReq = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    check("rst_mid_nowrite", 32'(sram[16'h0300]), 32'(init_word(16'h0300)));
    do_read(1'b1, 16'h0300, "rst_mid_rd");

    for (int t = 0; t < 24; t++) begin
      p = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      w = 16'($urandom);
      if (p && ($urandom_range(0, 1) == 1)) do_write(a, w, $sformatf("rnd%0d_wr", t));
      else do_read(p, a, $sformatf("rnd%0d_rd", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
